// File: rtl/hwpe_ctrl_regfile_bist.sv
// March C- self-test initiator for the HWPE control regfile test port.
// Runs two backgrounds back-to-back and records the first read mismatch.
module hwpe_ctrl_regfile_bist #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_BYTE   = DATA_WIDTH/8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   output logic                  bist_o,
   output logic                  csn_o,
   output logic                  wen_o,
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic [DATA_WIDTH-1:0] wdata_o,
   output logic [NUM_BYTE-1:0]   be_o,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  fail_o,
   output logic [ADDR_WIDTH-1:0] fail_addr_o,
   output logic [2:0]            fail_elem_o,
   output logic                  fail_pass_o
);

   // state | meaning
   // IDLE  | waiting for start, bus parked
   // RUN   | issuing March C- ops, one per cycle
   // DRAIN | no op, compares the last read
   // DONE  | results held until start or reset
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
   localparam logic [DATA_WIDTH-1:0] PAT_55   = {(DATA_WIDTH/2){2'b01}};

   logic [1:0]            state_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            elem_q;
   logic                  pass_q;
   logic                  phase_q;

   logic                  chk_valid_q;
   logic [DATA_WIDTH-1:0] chk_exp_q;
   logic [ADDR_WIDTH-1:0] chk_addr_q;
   logic [2:0]            chk_elem_q;
   logic                  chk_pass_q;

   logic                  fail_q;
   logic [ADDR_WIDTH-1:0] fail_addr_q;
   logic [2:0]            fail_elem_q;
   logic                  fail_pass_q;

   logic [DATA_WIDTH-1:0] d0, d1, wr_pat, rd_exp;
   logic                  two_op, desc, is_read, op_last, addr_last, elem_last;

   always_comb begin
      d0        = pass_q ? PAT_55 : '0;
      d1        = ~d0;
      two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
      desc      = (elem_q == 3'd3) || (elem_q == 3'd4);
      is_read   = two_op ? ~phase_q : (elem_q == 3'd5);
      // Odd elements write D1; reads expect what the previous element wrote.
      wr_pat    = elem_q[0] ? d1 : d0;
      rd_exp    = elem_q[0] ? d0 : d1;
      op_last   = ~two_op | phase_q;
      addr_last = desc ? (addr_q == '0) : (addr_q == ADDR_MAX);
      elem_last = (elem_q == 3'd5);
   end

   always_comb begin
      csn_o   = 1'b1;
      wen_o   = 1'b1;
      addr_o  = '0;
      wdata_o = '0;
      be_o    = '0;
      if (state_q == S_RUN) begin
         csn_o   = 1'b0;
         wen_o   = is_read;
         addr_o  = addr_q;
         wdata_o = is_read ? '0 : wr_pat;
         be_o    = is_read ? '0 : '1;
      end
   end

   assign busy_o      = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bist_o      = busy_o;
   assign done_o      = (state_q == S_DONE);
   assign fail_o      = fail_q;
   assign fail_addr_o = fail_addr_q;
   assign fail_elem_o = fail_elem_q;
   assign fail_pass_o = fail_pass_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         elem_q      <= '0;
         pass_q      <= 1'b0;
         phase_q     <= 1'b0;
         chk_valid_q <= 1'b0;
         chk_exp_q   <= '0;
         chk_addr_q  <= '0;
         chk_elem_q  <= '0;
         chk_pass_q  <= 1'b0;
         fail_q      <= 1'b0;
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         fail_pass_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               chk_valid_q <= 1'b0;
               if (start_i) begin
                  state_q     <= S_RUN;
                  addr_q      <= '0;
                  elem_q      <= '0;
                  pass_q      <= 1'b0;
                  phase_q     <= 1'b0;
                  fail_q      <= 1'b0;
                  fail_addr_q <= '0;
                  fail_elem_q <= '0;
                  fail_pass_q <= 1'b0;
               end
            end
            S_RUN: begin
               chk_valid_q <= is_read;
               chk_exp_q   <= rd_exp;
               chk_addr_q  <= addr_q;
               chk_elem_q  <= elem_q;
               chk_pass_q  <= pass_q;
               if (!op_last) begin
                  phase_q <= 1'b1;
               end else begin
                  phase_q <= 1'b0;
                  if (!addr_last) begin
                     addr_q <= desc ? addr_q - 1'b1 : addr_q + 1'b1;
                  end else if (elem_last) begin
                     elem_q <= '0;
                     addr_q <= '0;
                     pass_q <= ~pass_q;
                     if (pass_q) state_q <= S_DRAIN;
                  end else begin
                     elem_q <= elem_q + 3'd1;
                     // Elements 3 and 4 walk downward from the top address.
                     addr_q <= ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
                  end
               end
            end
            S_DRAIN: begin
               chk_valid_q <= 1'b0;
               state_q     <= S_DONE;
            end
            default: state_q <= S_IDLE;
         endcase

         if (chk_valid_q && (rdata_i != chk_exp_q) && !fail_q) begin
            fail_q      <= 1'b1;
            fail_addr_q <= chk_addr_q;
            fail_elem_q <= chk_elem_q;
            fail_pass_q <= chk_pass_q;
         end
      end
   end

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist.sv
// Directed bench: behavioural regfile with selectable faults and an
// independently generated March C- op trace for the fault-free run.
module tb_hwpe_ctrl_regfile_bist;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NB = DW/8;
   localparam int N  = 2**AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          bist_o, csn_o, wen_o, busy_o, done_o, fail_o, fail_pass_o;
   logic [AW-1:0] addr_o, fail_addr_o;
   logic [DW-1:0] wdata_o, rdata;
   logic [NB-1:0] be_o;
   logic [2:0]    fail_elem_o;

   int compared = 0;
   int mismatched = 0;

   hwpe_ctrl_regfile_bist #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_BYTE(NB)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start),
      .bist_o(bist_o), .csn_o(csn_o), .wen_o(wen_o), .addr_o(addr_o),
      .wdata_o(wdata_o), .be_o(be_o), .rdata_i(rdata),
      .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
      .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o), .fail_pass_o(fail_pass_o)
   );

   always #5 clk = ~clk;

   // 0: fault-free, 1: addr 7 bit 3 stuck-0, 2: write 8 also writes 9, 3: addr 20 bit 0 stuck-1
   int            mode = 0;
   logic [DW-1:0] mem [N];

   always @(posedge clk) begin
      logic [DW-1:0] tmp;
      if (bist_o && !csn_o) begin
         if (!wen_o) begin
            mem[addr_o] <= wdata_o;
            if (mode == 2 && addr_o == 5'd8) mem[9] <= wdata_o;
         end else begin
            tmp = mem[addr_o];
            if (mode == 1 && addr_o == 5'd7)  tmp[3] = 1'b0;
            if (mode == 3 && addr_o == 5'd20) tmp[0] = 1'b1;
            rdata <= tmp;
         end
      end
   end

   typedef struct packed {
      logic          wen;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } op_t;

   op_t expq[$];
   int  trace_idx = 0;
   int  trace_err = 0;
   bit  trace_en  = 1'b0;

   always @(negedge clk) begin
      if (trace_en && !csn_o) begin
         if (trace_idx >= expq.size()) trace_err++;
         else if (wen_o !== expq[trace_idx].wen || addr_o !== expq[trace_idx].addr ||
                  wdata_o !== expq[trace_idx].data || (!wen_o && be_o !== 4'hF))
            trace_err++;
         trace_idx++;
      end
   end

   task automatic push_op(input logic w, input int a, input logic [DW-1:0] d);
      op_t o;
      o.wen = w; o.addr = a[AW-1:0]; o.data = w ? '0 : d;
      expq.push_back(o);
   endtask

   task automatic build_trace();
      logic [DW-1:0] b0, b1;
      for (int p = 0; p < 2; p++) begin
         b0 = (p == 1) ? 32'h5555_5555 : 32'h0;
         b1 = ~b0;
         for (int a = 0; a < N; a++) push_op(1'b0, a, b0);
         for (int a = 0; a < N; a++) begin push_op(1'b1, a, '0); push_op(1'b0, a, b1); end
         for (int a = 0; a < N; a++) begin push_op(1'b1, a, '0); push_op(1'b0, a, b0); end
         for (int a = N-1; a >= 0; a--) begin push_op(1'b1, a, '0); push_op(1'b0, a, b1); end
         for (int a = N-1; a >= 0; a--) begin push_op(1'b1, a, '0); push_op(1'b0, a, b0); end
         for (int a = 0; a < N; a++) push_op(1'b1, a, '0);
      end
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_bus"}, {bist_o, csn_o, wen_o, busy_o, done_o}, 5'b01100);
      check({tag, "_addr_data_be"}, {addr_o, wdata_o, be_o}, '0);
      check({tag, "_fail"}, {fail_o, fail_addr_o, fail_elem_o, fail_pass_o}, '0);
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic run_to_done(output int n);
      n = 0;
      while (busy_o && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic check_result(input string tag, input int n, input logic f,
                               input int fa, input int fe, input logic fp);
      check({tag, "_busy_cycles"}, n, 20*N+1);
      check({tag, "_done"}, {done_o, busy_o, bist_o, csn_o}, 4'b1001);
      check({tag, "_fail"}, fail_o, f);
      if (f) check({tag, "_diag"}, {fail_addr_o, fail_elem_o, fail_pass_o}, {fa[AW-1:0], fe[2:0], fp});
   endtask

   initial begin
      int n;
      build_trace();
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("idle");

      // Fault-free run with full bus trace comparison.
      mode = 0; trace_idx = 0; trace_err = 0; trace_en = 1'b1;
      pulse_start();
      check("first_op", {bist_o, busy_o, csn_o, wen_o, addr_o, wdata_o, be_o}, {4'b1100, 5'd0, 32'h0, 4'hF});
      run_to_done(n);
      trace_en = 1'b0;
      check_result("clean", n, 1'b0, 0, 0, 1'b0);
      check("trace_ops", trace_idx, 20*N);
      check("trace_err", trace_err, 0);

      mode = 1;
      pulse_start();
      run_to_done(n);
      check_result("stuck0_a7b3", n, 1'b1, 7, 2, 1'b0);

      // Restart from DONE with fail set must clear the results.
      mode = 3;
      pulse_start();
      check("restart_clear", {done_o, fail_o, fail_addr_o, fail_elem_o, busy_o}, {2'b00, 5'd0, 3'd0, 1'b1});
      run_to_done(n);
      check_result("stuck1_a20b0", n, 1'b1, 20, 1, 1'b0);

      mode = 2;
      pulse_start();
      run_to_done(n);
      check_result("decoder_8_9", n, 1'b1, 9, 1, 1'b0);

      // Reset in the middle of RUN.
      mode = 0;
      pulse_start();
      repeat (99) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("midrun_reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle("post_reset_idle");
      pulse_start();
      run_to_done(n);
      check_result("after_reset", n, 1'b0, 0, 0, 1'b0);

      // start held high through RUN: no restart, then immediate restart from DONE.
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      run_to_done(n);
      check_result("start_held", n, 1'b0, 0, 0, 1'b0);
      @(negedge clk);
      check("held_restart", {busy_o, done_o, csn_o, wen_o}, 4'b1000);
      start = 1'b0;
      run_to_done(n);
      check_result("held_second", n, 1'b0, 0, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
